// File: rtl/wbq_pkg.sv
// Shared widths, depth default and queue entry layout for the writeback queue.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package wbq_pkg;

    localparam int WBQ_DEPTH  = 4;
    localparam int WBQ_DATA_W = 16;
    localparam int WBQ_SEL_W  = 3;

    // One pending register-file write; valid marks a live slot in the ring.
    typedef struct packed {
        logic                  valid;
        logic [WBQ_SEL_W-1:0]  regSel;
        logic [WBQ_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-match search over the queue ring for one forwarding lookup port.
// Latency: purely combinational.
// Backpressure: none; it only observes the entry array.
module wbq_match #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]             i_valid,
    input  logic [DEPTH-1:0][SEL_W-1:0]  i_sel,
    input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
    input  logic [PTR_W-1:0]             i_head,
    input  logic [SEL_W-1:0]             i_look_sel,
    output logic                         o_hit,
    output logic [DATA_W-1:0]            o_data
);

    // Walk oldest to youngest starting at head; a later match overrides, so the youngest wins.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_valid[w_idx] && (i_sel[w_idx] == i_look_sel)) begin
                o_hit  = 1'b1;
                o_data = i_data[w_idx];
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the 8x16b register file, with two forwarding lookups.
// Latency: one cycle from accept to write port; zero when WBQ_BYPASS_EN is defined and the queue is empty.
// Backpressure: reqReady drops when full (independent of a same-cycle drain); wbStall holds the head.
module wb_write_queue
    import wbq_pkg::*;
#(
    // Entry widths come from wbq_pkg::entry_t, so DATA_W/SEL_W track the package values.
    parameter int DEPTH  = WBQ_DEPTH,
    parameter int DATA_W = WBQ_DATA_W,
    parameter int SEL_W  = WBQ_SEL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reqValid,
    input  logic [SEL_W-1:0]           reqRegSel,
    input  logic [DATA_W-1:0]          reqData,
    output logic                       reqReady,
    input  logic                       wbStall,
    output logic [SEL_W-1:0]           writeRegSel,
    output logic [DATA_W-1:0]          writeData,
    output logic                       writeEn,
    input  logic [SEL_W-1:0]           look1RegSel,
    output logic                       look1Hit,
    output logic [DATA_W-1:0]          look1Data,
    input  logic [SEL_W-1:0]           look2RegSel,
    output logic                       look2Hit,
    output logic [DATA_W-1:0]          look2Data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t               r_entries [DEPTH];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic                 r_err;
    logic                 r_prev_blocked;
    logic [SEL_W-1:0]     r_prev_sel;
    logic [DATA_W-1:0]    r_prev_data;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_q_pop;
    logic                 w_bypass;
    logic                 w_push;
    logic                 w_violation;

    logic [DEPTH-1:0]             w_valid;
    logic [DEPTH-1:0][SEL_W-1:0]  w_sel;
    logic [DEPTH-1:0][DATA_W-1:0] w_data;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Head drains whenever something is pending and the file port is free; reset kills the write.
    assign w_q_pop = !rst && !w_empty && !wbStall;

`ifdef WBQ_BYPASS_EN
    // Empty queue and free port: the request skips the ring and writes in the same cycle.
    assign w_bypass = !rst && w_empty && !wbStall && reqValid;
`else
    assign w_bypass = 1'b0;
`endif

    // Readiness looks only at occupancy so a full queue refuses even while draining.
    assign reqReady = !rst && !w_full;
    assign w_push   = reqValid && reqReady && !w_bypass;

    assign writeEn     = w_q_pop || w_bypass;
    assign writeRegSel = w_q_pop ? r_entries[r_head].regSel :
                         (w_bypass ? reqRegSel : '0);
    assign writeData   = w_q_pop ? r_entries[r_head].data :
                         (w_bypass ? reqData : '0);

    assign count = r_count;
    assign err   = r_err;

    // A producer that was refused last cycle must hold its request unchanged.
    assign w_violation = r_prev_blocked &&
                         (!reqValid || (reqRegSel != r_prev_sel) || (reqData != r_prev_data));

    // Flatten the ring for the lookup searchers; lookups miss while reset is asserted.
    always_comb begin
        w_valid = '0;
        w_sel   = '0;
        w_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = r_entries[i].valid && !rst;
            w_sel[i]   = r_entries[i].regSel;
            w_data[i]  = r_entries[i].data;
        end
    end

    wbq_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .PTR_W  (PTR_W)
    ) u_match1 (
        .i_valid    (w_valid),
        .i_sel      (w_sel),
        .i_data     (w_data),
        .i_head     (r_head),
        .i_look_sel (look1RegSel),
        .o_hit      (look1Hit),
        .o_data     (look1Data)
    );

    wbq_match #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .PTR_W  (PTR_W)
    ) u_match2 (
        .i_valid    (w_valid),
        .i_sel      (w_sel),
        .i_data     (w_data),
        .i_head     (r_head),
        .i_look_sel (look2RegSel),
        .o_hit      (look2Hit),
        .o_data     (look2Data)
    );

    // Ring pointers, occupancy, entry storage and the sticky handshake monitor.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_err          <= 1'b0;
            r_prev_blocked <= 1'b0;
            r_prev_sel     <= '0;
            r_prev_data    <= '0;
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= '{valid: 1'b1, regSel: reqRegSel, data: reqData};
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_q_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            r_count        <= r_count + CNT_W'(w_push) - CNT_W'(w_q_pop);
            r_prev_blocked <= reqValid && !reqReady;
            r_prev_sel     <= reqRegSel;
            r_prev_data    <= reqData;
            if (w_violation) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: directed scenarios plus randomized traffic.
// Latency: checks one-cycle drain (or same-cycle bypass when WBQ_BYPASS_EN is defined).
// Backpressure: exercises full-queue refusal, wbStall, err on dropped requests and mid-run reset.
module tb_wb_write_queue;

    localparam int DEPTH = 4;
`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic [2:0]  reqRegSel = '0;
    logic [15:0] reqData = '0;
    logic        reqReady;
    logic        wbStall = 1'b0;
    logic [2:0]  writeRegSel;
    logic [15:0] writeData;
    logic        writeEn;
    logic [2:0]  look1RegSel = '0;
    logic        look1Hit;
    logic [15:0] look1Data;
    logic [2:0]  look2RegSel = '0;
    logic        look2Hit;
    logic [15:0] look2Data;
    logic [2:0]  count;
    logic        err;

    wb_write_queue dut (
        .clk         (clk),
        .rst         (rst),
        .reqValid    (reqValid),
        .reqRegSel   (reqRegSel),
        .reqData     (reqData),
        .reqReady    (reqReady),
        .wbStall     (wbStall),
        .writeRegSel (writeRegSel),
        .writeData   (writeData),
        .writeEn     (writeEn),
        .look1RegSel (look1RegSel),
        .look1Hit    (look1Hit),
        .look1Data   (look1Data),
        .look2RegSel (look2RegSel),
        .look2Hit    (look2Hit),
        .look2Data   (look2Data),
        .count       (count),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
    } wr_t;

    // Reference state: pending writes in age order, plus the handshake-violation flag.
    wr_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_en  = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_bypass = 1'b0;
    bit          last_acc = 1'b0;
    bit          model_err = 1'b0;
    bit          prev_blocked = 1'b0;
    logic [2:0]  psel = '0;
    logic [15:0] pdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void lookup(input logic [2:0] s, output bit h, output logic [15:0] d);
        h = 1'b0;
        d = '0;
        if (!rst) begin
            for (int i = 0; i < sb.size(); i++) begin
                if (sb[i].sel == s) begin
                    h = 1'b1;
                    d = sb[i].data;
                end
            end
        end
    endfunction

    // Monitor: compare every DUT output against the reference, consume the drained entry.
    always @(negedge clk) begin
        int          sz;
        bit          exp_we;
        bit          h;
        logic [15:0] d;
        if (mon_en) begin
            sz       = sb.size();
            m_ready  = !rst && (sz != DEPTH);
            m_bypass = BYP && !rst && (sz == 0) && !wbStall && reqValid;
            exp_we   = !rst && ((sz != 0 && !wbStall) || m_bypass);
            check("reqReady", 32'(reqReady), 32'(m_ready));
            check("count", 32'(count), 32'(sz));
            check("err", 32'(err), 32'(model_err));
            check("writeEn", 32'(writeEn), 32'(exp_we));
            lookup(look1RegSel, h, d);
            check("look1Hit", 32'(look1Hit), 32'(h));
            check("look1Data", 32'(look1Data), 32'(d));
            lookup(look2RegSel, h, d);
            check("look2Hit", 32'(look2Hit), 32'(h));
            check("look2Data", 32'(look2Data), 32'(d));
            if (m_bypass) begin
                check("bypassSel", 32'(writeRegSel), 32'(reqRegSel));
                check("bypassData", 32'(writeData), 32'(reqData));
            end else if (exp_we) begin
                check("writeRegSel", 32'(writeRegSel), 32'(sb[0].sel));
                check("writeData", 32'(writeData), 32'(sb[0].data));
                void'(sb.pop_front());
            end else begin
                check("idleSel", 32'(writeRegSel), 32'd0);
                check("idleData", 32'(writeData), 32'd0);
            end
        end
    end

    // Stimulus side of the scoreboard: record accepted requests and handshake violations at the edge.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            model_err    = 1'b0;
            prev_blocked = 1'b0;
            last_acc     = 1'b0;
        end else begin
            if (prev_blocked && (!reqValid || reqRegSel != psel || reqData != pdata))
                model_err = 1'b1;
            last_acc = reqValid && m_ready;
            if (last_acc && !m_bypass)
                sb.push_back('{sel: reqRegSel, data: reqData});
            prev_blocked = reqValid && !m_ready;
            psel  = reqRegSel;
            pdata = reqData;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] s, input logic [15:0] d, input int budget);
        bit done;
        done      = 1'b0;
        reqValid  = 1'b1;
        reqRegSel = s;
        reqData   = d;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (last_acc) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL push_timeout R%0d=%0h: not accepted in %0d cycles", s, d, budget);
        end
        reqValid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        tick();
        mon_en = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Single write, drained the cycle after accept.
        push(3'd3, 16'h1234, 10);
        repeat (3) tick();

        // Fill under stall, hold a fifth request, then release.
        wbStall = 1'b1;
        for (int i = 1; i <= 4; i++) push(3'(i), 16'(i), 10);
        reqValid = 1'b1; reqRegSel = 3'd5; reqData = 16'h0005;
        repeat (3) tick();
        wbStall = 1'b0;
        push(3'd5, 16'h0005, 10);
        repeat (6) tick();

        // Duplicate destination: lookup must return the younger value.
        wbStall = 1'b1;
        push(3'd5, 16'hAAAA, 10);
        push(3'd5, 16'hBBBB, 10);
        look1RegSel = 3'd5;
        look2RegSel = 3'd6;
        repeat (2) tick();
        wbStall = 1'b0;
        repeat (4) tick();

        // Steady push+pop at count 2 across pointer wrap.
        wbStall = 1'b1;
        push(3'd0, 16'h00F0, 10);
        push(3'd1, 16'h00F1, 10);
        wbStall = 1'b0;
        for (int i = 0; i < 10; i++) push(3'(i), 16'h0100 + 16'(i), 10);
        repeat (4) tick();

        // Randomized legal traffic: refused requests are held stable.
        for (int c = 0; c < 400; c++) begin
            if (!reqValid || last_acc) begin
                reqValid  = ($urandom_range(0, 2) != 0);
                reqRegSel = 3'($urandom_range(0, 7));
                reqData   = 16'($urandom);
            end
            wbStall     = ($urandom_range(0, 3) == 0);
            look1RegSel = 3'($urandom_range(0, 7));
            look2RegSel = 3'($urandom_range(0, 7));
            tick();
        end
        reqValid = 1'b0;
        wbStall  = 1'b0;
        repeat (6) tick();

        // Drop a refused request: err sets and sticks; reset clears it and discards entries.
        wbStall = 1'b1;
        for (int i = 0; i < 4; i++) push(3'(i + 2), 16'hC000 + 16'(i), 10);
        reqValid = 1'b1; reqRegSel = 3'd7; reqData = 16'hDEAD;
        repeat (2) tick();
        reqValid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        wbStall = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Bypass / empty-queue write of R7.
        push(3'd7, 16'hBEEF, 10);
        repeat (3) tick();

        // Unconstrained random traffic with violations and occasional reset.
        for (int c = 0; c < 400; c++) begin
            reqValid    = ($urandom_range(0, 1) != 0);
            reqRegSel   = 3'($urandom_range(0, 7));
            reqData     = 16'($urandom_range(0, 3));
            wbStall     = ($urandom_range(0, 2) == 0);
            rst         = ($urandom_range(0, 40) == 0);
            look1RegSel = 3'($urandom_range(0, 7));
            look2RegSel = 3'($urandom_range(0, 7));
            tick();
        end
        rst      = 1'b0;
        reqValid = 1'b0;
        wbStall  = 1'b0;
        repeat (6) tick();

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
